// File: rtl/uart_frame_parser.sv
// uart_frame_parser
// Takes bytes from a UART receiver and assembles command frames:
//   START, LEN, CMD, payload[LEN-1], END
// It emits the command byte and an indexed payload write stream, and
// acknowledges every received byte. Malformed frames, line errors and
// stalled frames are aborted and reported with a one-cycle error pulse.
//
// Ports
//   clk             in   system clock
//   rst             in   asynchronous reset, active low
//   Rx_data         in   received byte, valid while new_Rx is high
//   new_Rx          in   UART "byte received" level flag
//   Rx_error        in   framing/stop-bit error for the current byte
//   clear_interrupt out  one-cycle acknowledge pulse back to the UART
//   cmd             out  last accepted CMD byte
//   data_out        out  payload byte
//   data_idx        out  payload index, 0-based
//   data_we         out  one-cycle payload write strobe
//   frame_done      out  one-cycle pulse on a correctly terminated frame
//   frame_error     out  one-cycle pulse on an aborted frame
//   busy            out  high while a frame is in progress
//
// state    | meaning
// ---------+----------------------------------------------
// IDLE     | waiting for START; other bytes are discarded
// GET_LEN  | next byte is LEN (CMD + payload byte count)
// GET_CMD  | next byte is the command
// GET_DATA | collecting payload bytes
// GET_END  | next byte must be END

module uart_frame_parser #(
  parameter int                     WORD_LENGHT    = 8,
  parameter int                     MAX_LEN        = 16,
  parameter int                     TIMEOUT_CYCLES = 100000,
  parameter logic [WORD_LENGHT-1:0] START_BYTE     = 8'hFE,
  parameter logic [WORD_LENGHT-1:0] END_BYTE       = 8'hEF,
  localparam int                    IDX_W          = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORD_LENGHT-1:0] Rx_data,
  input  logic                   new_Rx,
  input  logic                   Rx_error,
  output logic                   clear_interrupt,
  output logic [WORD_LENGHT-1:0] cmd,
  output logic [WORD_LENGHT-1:0] data_out,
  output logic [IDX_W-1:0]       data_idx,
  output logic                   data_we,
  output logic                   frame_done,
  output logic                   frame_error,
  output logic                   busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [TW-1:0]          TO_LIMIT = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]          TO_ONE   = TW'(1);
  localparam logic [WORD_LENGHT-1:0] LEN_MAX  = WORD_LENGHT'(MAX_LEN);
  localparam logic [WORD_LENGHT-1:0] W_ONE    = WORD_LENGHT'(1);
  localparam logic [IDX_W-1:0]       IDX_ONE  = IDX_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_LEN,
    ST_GET_CMD,
    ST_GET_DATA,
    ST_GET_END
  } state_t;

  state_t                 state_q;
  logic                   new_rx_q;
  logic [WORD_LENGHT-1:0] remaining_q;
  logic [IDX_W-1:0]       idx_q;
  logic [TW-1:0]          timer_q;
  logic                   clr_q;
  logic [WORD_LENGHT-1:0] cmd_q;
  logic [WORD_LENGHT-1:0] data_out_q;
  logic [IDX_W-1:0]       data_idx_q;
  logic                   data_we_q;
  logic                   done_q;
  logic                   err_q;
  logic                   accept_d;

  // new_Rx is a level held until the UART sees clear_interrupt, so only its
  // rising edge counts as a new byte.
  assign accept_d = new_Rx & ~new_rx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      new_rx_q    <= 1'b0;
      remaining_q <= '0;
      idx_q       <= '0;
      timer_q     <= '0;
      clr_q       <= 1'b0;
      cmd_q       <= '0;
      data_out_q  <= '0;
      data_idx_q  <= '0;
      data_we_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      new_rx_q  <= new_Rx;
      clr_q     <= accept_d;
      data_we_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;

      if (accept_d) begin
        // A byte arriving on the expiry cycle wins over the timeout.
        timer_q <= '0;
        if (state_q != ST_IDLE && Rx_error) begin
          err_q   <= 1'b1;
          state_q <= ST_IDLE;
        end else begin
          unique case (state_q)
            ST_IDLE: begin
              if (Rx_data == START_BYTE && !Rx_error) state_q <= ST_GET_LEN;
            end
            ST_GET_LEN: begin
              if (Rx_data == '0 || Rx_data > LEN_MAX) begin
                err_q   <= 1'b1;
                state_q <= ST_IDLE;
              end else begin
                remaining_q <= Rx_data - W_ONE;
                state_q     <= ST_GET_CMD;
              end
            end
            ST_GET_CMD: begin
              cmd_q <= Rx_data;
              idx_q <= '0;
              if (remaining_q == '0) state_q <= ST_GET_END;
              else                   state_q <= ST_GET_DATA;
            end
            ST_GET_DATA: begin
              data_out_q <= Rx_data;
              data_idx_q <= idx_q;
              data_we_q  <= 1'b1;
              idx_q      <= idx_q + IDX_ONE;
              if (remaining_q != '0) remaining_q <= remaining_q - W_ONE;
              if (remaining_q == W_ONE) state_q <= ST_GET_END;
            end
            ST_GET_END: begin
              if (Rx_data == END_BYTE) done_q <= 1'b1;
              else                     err_q  <= 1'b1;
              state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
          endcase
        end
      end else if (state_q != ST_IDLE) begin
        // Saturating compare: the counter stops at the limit and the
        // frame is dropped, so it never wraps.
        if (timer_q == TO_LIMIT) begin
          err_q   <= 1'b1;
          state_q <= ST_IDLE;
          timer_q <= '0;
        end else begin
          timer_q <= timer_q + TO_ONE;
        end
      end else begin
        timer_q <= '0;
      end
    end
  end

  assign clear_interrupt = clr_q;
  assign cmd             = cmd_q;
  assign data_out        = data_out_q;
  assign data_idx        = data_idx_q;
  assign data_we         = data_we_q;
  assign frame_done      = done_q;
  assign frame_error     = err_q;
  assign busy            = (state_q != ST_IDLE);

endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Downstream consumer of the UART receiver. Takes each received byte (`Rx_out`/`new_Rx`/`Rx_error`) and assembles command frames of the form START, LEN, CMD, payload, END. It emits the command and an indexed payload write stream for the command-execution logic. It acknowledges every byte through `clear_interrupt`, aborts malformed or stalled frames, and reports them with a one-cycle error pulse.

## Interface
- `WORD_LENGHT`, 8: byte width; must match the UART.
- `MAX_LEN`, 16: maximum LEN field value (CMD + payload bytes); 1..255.
- `TIMEOUT_CYCLES`, 100000: idle clocks allowed between bytes inside a frame before abort; ≥2.
- `START_BYTE`, 8'hFE: frame opener.
- `END_BYTE`, 8'hEF: frame terminator.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  asynchronous, active-low reset.
- `Rx_data`  in  WORD_LENGHT  received byte (UART `Rx_out`); valid while `new_Rx` is high.
- `new_Rx`  in  1  UART received flag; a level held until cleared.
- `Rx_error`  in  1  framing/stop-bit error for the current byte.
- `clear_interrupt`  out  1  one-cycle pulse acknowledging the byte, wired to the UART.
- `cmd`  out  WORD_LENGHT  last accepted CMD byte.
- `data_out`  out  WORD_LENGHT  payload byte.
- `data_idx`  out  $clog2(MAX_LEN)  payload index, 0-based.
- `data_we`  out  1  one-cycle payload write strobe.
- `frame_done`  out  1  one-cycle pulse when a frame completes correctly.
- `frame_error`  out  1  one-cycle pulse when a frame aborts.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- **Byte accept:** a byte is accepted on the cycle where `new_Rx` is high and its registered copy is low (rising edge). Holding `new_Rx` high never produces a second accept.
- **Acknowledge:** every accepted byte, in any state, produces `clear_interrupt` = 1 on the following cycle.
- **States:** IDLE, GET_LEN, GET_CMD, GET_DATA, GET_END.
- **IDLE:**
  - Byte == START_BYTE with `Rx_error` = 0 → GET_LEN.
  - Any other byte is acknowledged and discarded; no error pulse.
- **GET_LEN:**
  - Store LEN.
  - LEN = 0 or LEN > MAX_LEN → abort.
  - Otherwise load `remaining` = LEN − 1 and go to GET_CMD.
- **GET_CMD:**
  - `cmd` ← byte.
  - `remaining` = 0 → GET_END; else → GET_DATA with index 0.
- **GET_DATA:**
  - Each byte: `data_out` ← byte, `data_idx` ← index, `data_we` pulse.
  - Then index++ and `remaining`--.
  - Go to GET_END when the last payload byte has been written.
- **GET_END:**
  - Byte == END_BYTE → `frame_done` pulse, then IDLE.
  - Any other byte → abort.
- **Rx_error:** an accepted byte with `Rx_error` = 1 in any non-IDLE state → abort. In IDLE it is discarded.
- **Timeout:**
  - A counter clears on every accept and increments each cycle while `busy`.
  - Reaching TIMEOUT_CYCLES → abort.
- **Abort:** `frame_error` pulse, return to IDLE. `cmd` and already-written payload are not rolled back.
- **Widths:**
  - LEN is compared at full WORD_LENGHT width.
  - `remaining` and the timeout counter are unsigned and never wrap.
  - `data_idx` maximum is MAX_LEN − 2.

## Timing
- **Reset values:** all outputs 0, `cmd` = 0, state IDLE, counters 0, edge-detect register 0.
- **Latency:** `clear_interrupt`, `data_we`/`data_out`/`data_idx`, `frame_done` and `frame_error` are all registered and assert exactly 1 cycle after the accept (or timeout) cycle, for exactly 1 cycle.
- **`cmd`:** updates 1 cycle after the CMD accept and holds until the next CMD accept or reset.
- **`busy`:** rises 1 cycle after START is accepted. It falls in the same cycle `frame_done` or `frame_error` is high.
- **Simultaneous byte accept and timeout expiry:** the byte wins; the counter clears and no abort occurs.
- **Back-to-back frames:** a START accepted the cycle after END is handled normally.
- **Reset mid-frame:** immediate return to reset values. A byte pending in the UART is treated as new once `rst` is released and `new_Rx` is high: the edge register resets to 0, so the byte is accepted.

## Test plan
- **Normal frame:** FE 03 A5 11 22 EF → `cmd` = A5; `data_we` pulses (idx 0, 11) and (idx 1, 22); one `frame_done`; six `clear_interrupt` pulses; `busy` low afterwards.
- **Command-only frame:** FE 01 3C EF → `cmd` = 3C, no `data_we`, `frame_done` pulse. Then 55 FE in IDLE → 55 discarded without error and a new frame starts.
- **Length errors:** FE 00 → `frame_error` one cycle after the LEN accept. FE 11 with MAX_LEN = 16 → `frame_error`. Both return to IDLE.
- **Bad terminator:** FE 02 10 20 EE → `data_we` for 20 at idx 0, then `frame_error` (no `frame_done`). A following FE 01 77 EF completes normally.
- **Timeout:** TIMEOUT_CYCLES = 50; send FE 02, then stall → `frame_error` exactly 1 cycle after count 50. Separately, a byte on exactly the expiry cycle → no error.
- **Line error and reset:** `Rx_error` = 1 on the CMD byte → `frame_error`. `new_Rx` held high 10 cycles → a single accept. `rst` asserted during GET_DATA → all outputs 0 and IDLE.
